// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallFetch,
    input  logic                  StallDecode,
    input  logic                  FlushDecode,
    input  logic                  PCSrcE,
    input  logic [ADDR_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ready,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic [31:0]           FetchCnt,
    output logic [31:0]           BubbleCnt
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc_plus4;
        logic                  valid;
    } ifid_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pcf_q, pcf_d;
    logic [ADDR_WIDTH-1:0] pcf_plus4;
    ifid_t                 ifid_q, ifid_d;
    logic                  run;
    logic                  accept;
    logic                  ifid_load;

    // Instruction fetches are word aligned; the low target bits are dropped.
    logic [1:0] unused_target_lsbs;
    assign unused_target_lsbs = PCTargetE[1:0];

    // ---------------- control FSM ----------------
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values of its peers regardless of process order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
    end

    always_comb begin
        imem_req = (state_q == RUN);
    end

    assign run       = (state_q == RUN);
    assign accept    = run & imem_ready & ~StallFetch;
    assign pcf_plus4 = pcf_q + ADDR_WIDTH'(4);
    assign imem_addr = pcf_q;

    // ---------------- program counter ----------------
    always_comb begin
        pcf_d = pcf_q;
        if (run) begin
            if (PCSrcE) begin
                pcf_d = {PCTargetE[ADDR_WIDTH-1:2], 2'b00};
            end else if (!StallFetch && accept) begin
                pcf_d = pcf_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcf_q <= RESET_PC;
        end else begin
            pcf_q <= pcf_d;
        end
    end

    // ---------------- IF/ID register ----------------
    // A bubble keeps the old PC fields; only instr/valid describe the slot.
    always_comb begin
        ifid_d    = ifid_q;
        ifid_load = 1'b0;
        if (!run || FlushDecode) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
            ifid_load    = 1'b1;
        end else if (StallDecode) begin
            ifid_load = 1'b0;
        end else if (accept) begin
            ifid_d.instr    = imem_rdata;
            ifid_d.pc       = pcf_q;
            ifid_d.pc_plus4 = pcf_plus4;
            ifid_d.valid    = 1'b1;
            ifid_load       = 1'b1;
        end else begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
            ifid_load    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus4 <= '0;
            ifid_q.valid    <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

    // ---------------- performance counters ----------------
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (ifid_load) begin
            if (ifid_d.valid) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign FetchCnt  = fetch_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`else
    logic unused_ifid_load;
    assign unused_ifid_load = ifid_load;
    assign FetchCnt         = 32'd0;
    assign BubbleCnt        = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, counter sequence and
// randomized traffic against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] KEY      = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallFetch, StallDecode, FlushDecode, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCnt, BubbleCnt;

    logic [31:0] salt;
    int          tests  = 0;
    int          failed = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallFetch (StallFetch),
        .StallDecode(StallDecode),
        .FlushDecode(FlushDecode),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchCnt   (FetchCnt),
        .BubbleCnt  (BubbleCnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: contents are a fixed function of the address.
    assign imem_rdata = imem_addr ^ salt;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pcf, m_instr, m_pcd, m_pc4;
    bit          m_valid;
    logic [31:0] m_fcnt, m_bcnt;

    typedef struct {
        bit          rst_n, sf, sd, fd, ps;
        logic [31:0] tgt;
        bit          rdy;
        logic [31:0] addr, instr, pcd;
        bit          valid, req;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit sf, bit sd, bit fd, bit ps, logic [31:0] tgt,
                                bit rdy, logic [31:0] addr, logic [31:0] instr,
                                logic [31:0] pcd, bit valid, bit req);
        vec_t v;
        v.rst_n = r;   v.sf = sf;   v.sd = sd;   v.fd = fd;   v.ps = ps;
        v.tgt   = tgt; v.rdy = rdy; v.addr = addr; v.instr = instr;
        v.pcd   = pcd; v.valid = valid; v.req = req;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(bit r, bit sf, bit sd, bit fd, bit ps, logic [31:0] tgt, bit rdy);
        rst_n = r; StallFetch = sf; StallDecode = sd; FlushDecode = fd;
        PCSrcE = ps; PCTargetE = tgt; imem_ready = rdy;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit          acc;
        logic [31:0] fetched, old_pcf;
        if (!rst_n) begin
            m_run = 0; m_pcf = RESET_PC; m_instr = NOP; m_pcd = '0; m_pc4 = '0;
            m_valid = 0; m_fcnt = '0; m_bcnt = '0;
        end else begin
            acc     = m_run && imem_ready && !StallFetch;
            fetched = m_pcf ^ salt;
            old_pcf = m_pcf;
            if (m_run) begin
                if (PCSrcE) m_pcf = PCTargetE & ~32'd3;
                else if (acc) m_pcf = m_pcf + 32'd4;
            end
            if (!m_run || FlushDecode) begin
                m_instr = NOP; m_valid = 0; m_bcnt = m_bcnt + 1;
            end else if (StallDecode) begin
                m_instr = m_instr;
            end else if (acc) begin
                m_instr = fetched; m_pcd = old_pcf; m_pc4 = old_pcf + 32'd4;
                m_valid = 1; m_fcnt = m_fcnt + 1;
            end else begin
                m_instr = NOP; m_valid = 0; m_bcnt = m_bcnt + 1;
            end
            m_run = 1;
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, " req"}, {31'd0, imem_req}, {31'd0, m_run});
        check({tag, " addr"}, imem_addr, m_pcf);
        check({tag, " instr"}, InstrD, m_instr);
        check({tag, " valid"}, {31'd0, ValidD}, {31'd0, m_valid});
        if (m_valid) begin
            check({tag, " pcd"}, PCD, m_pcd);
            check({tag, " pc4"}, PCPlus4D, m_pc4);
        end
`ifdef FETCH_PERF_CNT_EN
        check({tag, " fcnt"}, FetchCnt, m_fcnt);
        check({tag, " bcnt"}, BubbleCnt, m_bcnt);
`else
        check({tag, " fcnt"}, FetchCnt, 32'd0);
        check({tag, " bcnt"}, BubbleCnt, 32'd0);
`endif
    endtask

    initial begin
        salt = KEY;
        drive(0, 0, 0, 0, 0, 32'd0, 0);

        // reset, stream, load-use stall, redirect, memory wait, flush, wrap
        vecs.push_back(mk(0,0,0,0,0,32'h0,0, 32'hBFC00000, NOP,          32'h0,        0, 0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,1, 32'hBFC00000, NOP,          32'h0,        0, 0));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC00000, NOP,          32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC00004, 32'h1A65A5A5, 32'hBFC00000, 1, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC00008, 32'h1A65A5A1, 32'hBFC00004, 1, 1));
        vecs.push_back(mk(1,1,1,0,0,32'h0,1, 32'hBFC00008, 32'h1A65A5A1, 32'hBFC00004, 1, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC0000C, 32'h1A65A5AD, 32'hBFC00008, 1, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC00010, 32'h1A65A5A9, 32'hBFC0000C, 1, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,0, 32'hBFC00010, NOP,          32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,0, 32'hBFC00010, NOP,          32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,0, 32'hBFC00010, NOP,          32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC00014, 32'h1A65A5B5, 32'hBFC00010, 1, 1));
        vecs.push_back(mk(1,1,0,1,1,32'hBFC00103,1, 32'hBFC00100, NOP,   32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'hBFC00104, 32'h1A65A4A5, 32'hBFC00100, 1, 1));
        vecs.push_back(mk(1,0,0,0,1,32'h00000010,0, 32'h00000010, NOP,   32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'h00000014, 32'hA5A5A5B5, 32'h00000010, 1, 1));
        vecs.push_back(mk(1,1,1,1,0,32'h0,1, 32'h00000014, NOP,          32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,1,32'hFFFFFFFF,0, 32'hFFFFFFFC, NOP,   32'h0,        0, 1));
        vecs.push_back(mk(1,0,0,0,0,32'h0,1, 32'h00000000, 32'h5A5A5A59, 32'hFFFFFFFC, 1, 1));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst_n, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps,
                  vecs[i].tgt, vecs[i].rdy);
            tick(tag);
            check({tag, " t_req"}, {31'd0, imem_req}, {31'd0, vecs[i].req});
            check({tag, " t_addr"}, imem_addr, vecs[i].addr);
            check({tag, " t_instr"}, InstrD, vecs[i].instr);
            check({tag, " t_valid"}, {31'd0, ValidD}, {31'd0, vecs[i].valid});
            if (vecs[i].valid || !vecs[i].rst_n) begin
                check({tag, " t_pcd"}, PCD, vecs[i].pcd);
                check({tag, " t_pc4"}, PCPlus4D, vecs[i].rst_n ? vecs[i].pcd + 32'd4 : 32'd0);
            end
        end

        // Counter sequence: 10 accepts, 3 wait cycles, then one more accept.
        drive(0, 0, 0, 0, 0, 32'd0, 1);
        tick("cnt_rst0");
        tick("cnt_rst1");
        drive(1, 0, 0, 0, 0, 32'd0, 1);
        tick("cnt_boot");
        for (int i = 0; i < 10; i++) tick($sformatf("cnt_acc%0d", i));
        imem_ready = 0;
        for (int i = 0; i < 3; i++) tick($sformatf("cnt_wait%0d", i));
        imem_ready = 1;
        tick("cnt_last");
        check("cnt instr", InstrD, 32'hBFC00028 ^ KEY);
`ifdef FETCH_PERF_CNT_EN
        check("cnt fetch11", FetchCnt, 32'd11);
        check("cnt bubble>=4", {31'd0, BubbleCnt >= 32'd4}, 32'd1);
`else
        check("cnt fetch0", FetchCnt, 32'd0);
        check("cnt bubble0", BubbleCnt, 32'd0);
`endif

        // Randomized traffic against the model.
        salt = $urandom;
        drive(0, 0, 0, 0, 0, 32'd0, 0);
        tick("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            bit sf;
            sf = ($urandom_range(0, 4) == 0);
            drive(($urandom_range(0, 99) != 0), sf,
                  sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  $urandom, ($urandom_range(0, 3) != 0));
            tick($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
